div_sequencer: RTL

- Multicycle controller for signed 32-bit division in the multdiv unit.
- Latches the operands on `ctrl_DIV` and converts them to magnitudes.
- Iterates a single restoring shift/subtract step 32 times over a 64-bit {remainder, quotient} register.
- Restores signs, flags divide-by-zero, and pulses `data_resultRDY`; sits between the multdiv front-end and the result mux.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_if.sv | 23 ++
 rtl/div_step.sv | 24 ++
 rtl/div_sequencer.sv | 112 +++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared widths, state encoding and magnitude helper for the signed divider.
package div_pkg;
  localparam int WIDTH = 32;
  localparam int ITERS = WIDTH;
  localparam int CNT_W = $clog2(ITERS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Unsigned magnitude of a two's-complement value; the most negative input maps to itself.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction
endpackage

// File: rtl/div_if.sv
// Operand/result bundle between the multdiv front-end and the divide sequencer.
interface div_if;
  import div_pkg::*;

  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic [WIDTH-1:0] data_remainder;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_remainder, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_remainder, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/div_step.sv
// One restoring shift/subtract iteration over the {remainder, quotient} register.
module div_step
  import div_pkg::*;
(
  input  logic [2*WIDTH-1:0] cur_reg,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] next_reg
);

  logic [2*WIDTH-1:0] shifted;
  logic [WIDTH:0]     diff;

  // A clear borrow bit means the partial remainder covers the divisor.
  always_comb begin
    shifted = cur_reg << 1;
    diff    = {1'b0, shifted[2*WIDTH-1:WIDTH]} - {1'b0, divisor};
    if (!diff[WIDTH]) begin
      next_reg = {diff[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
    end else begin
      next_reg = shifted;
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Multicycle signed 32-bit divider: latch magnitudes, iterate div_step, then restore signs.
module div_sequencer
  import div_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  div_if.slave  bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, step_out;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               quot_neg_q, quot_neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               exception_q, exception_d;
  logic               rdy_q, rdy_d;
  logic               busy_q, busy_d;

  div_step u_step (
    .cur_reg  (acc_q),
    .divisor  (divisor_q),
    .next_reg (step_out)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    divisor_d   = divisor_q;
    quot_neg_d  = quot_neg_q;
    rem_neg_d   = rem_neg_q;
    dz_d        = dz_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    exception_d = exception_q;
    rdy_d       = 1'b0;
    busy_d      = busy_q;

    // A start strobe wins in every state, aborting any run in flight.
    if (bus.ctrl_DIV) begin
      state_d    = S_RUN;
      count_d    = '0;
      acc_d      = {{WIDTH{1'b0}}, magnitude(bus.data_operandA)};
      divisor_d  = magnitude(bus.data_operandB);
      quot_neg_d = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      rem_neg_d  = bus.data_operandA[WIDTH-1];
      dz_d       = (bus.data_operandB == '0);
      busy_d     = 1'b1;
    end else begin
      case (state_q)
        S_RUN: begin
          acc_d   = step_out;
          count_d = count_q + CNT_W'(1);
          // The final step's output feeds the result registers directly.
          if (count_q == CNT_W'(ITERS - 1)) begin
            state_d     = S_DONE;
            busy_d      = 1'b0;
            rdy_d       = 1'b1;
            exception_d = dz_q;
            result_d    = dz_q ? '0 :
                          (quot_neg_q ? -step_out[WIDTH-1:0] : step_out[WIDTH-1:0]);
            remainder_d = dz_q ? '0 :
                          (rem_neg_q ? -step_out[2*WIDTH-1:WIDTH] : step_out[2*WIDTH-1:WIDTH]);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      acc_q       <= '0;
      divisor_q   <= '0;
      quot_neg_q  <= 1'b0;
      rem_neg_q   <= 1'b0;
      dz_q        <= 1'b0;
      result_q    <= '0;
      remainder_q <= '0;
      exception_q <= 1'b0;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      divisor_q   <= divisor_d;
      quot_neg_q  <= quot_neg_d;
      rem_neg_q   <= rem_neg_d;
      dz_q        <= dz_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      exception_q <= exception_d;
      rdy_q       <= rdy_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_remainder = remainder_q;
  assign bus.data_exception = exception_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;

endmodule
